// File: rtl/comparator_pkg.sv
// Shared types and result codes for the serial N-bit comparator family.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } result_t;

  localparam int unsigned RESULT_W = 3;

  localparam result_t GT = 3'b100;
  localparam result_t EQ = 3'b010;
  localparam result_t LT = 3'b001;

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned chunk comparator; optional MSB inversion turns the
// top chunk's unsigned compare into a two's-complement compare.
module comparator_chunk #(
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] Chunk_A_In,
  input  logic [CHUNK_WIDTH-1:0] Chunk_B_In,
  input  logic                   Invert_MSB_In,
  output logic                   gt_c,
  output logic                   eq_c,
  output logic                   lt_c
);

  logic [CHUNK_WIDTH-1:0] msb_mask_c;
  logic [CHUNK_WIDTH-1:0] a_mod_c;
  logic [CHUNK_WIDTH-1:0] b_mod_c;

  always_comb begin
    msb_mask_c = CHUNK_WIDTH'(Invert_MSB_In) << (CHUNK_WIDTH - 1);
    a_mod_c    = Chunk_A_In ^ msb_mask_c;
    b_mod_c    = Chunk_B_In ^ msb_mask_c;
    gt_c       = (a_mod_c > b_mod_c);
    eq_c       = (a_mod_c == b_mod_c);
    lt_c       = (a_mod_c < b_mod_c);
  end

endmodule

// File: rtl/comparator_n_bit_serial.sv
// Serial magnitude comparator: walks operands MS chunk first, one chunk per
// clock, and stops at the first unequal chunk. Flags are tri-stated by Enable_In.
module comparator_n_bit_serial
  import comparator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Start_In,
  input  logic                  Signed_Mode_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  A_gt_B_Out,
  output logic                  A_eq_B_Out,
  output logic                  A_lt_B_Out
);

  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, b_q;
  logic                   signed_q;
  logic [IDX_W-1:0]       idx_q;
  result_t                flags_q, flags_d;
  logic                   busy_q, done_q;
  logic                   load_c, step_c;

  logic [CHUNK_WIDTH-1:0] chunk_a_c, chunk_b_c;
  logic                   inv_msb_c;
  logic                   gt_c, eq_c, lt_c;

  // Select the chunk under examination; only the top chunk carries the sign.
  always_comb begin
    chunk_a_c = CHUNK_WIDTH'(a_q >> (32'(idx_q) * CHUNK_WIDTH));
    chunk_b_c = CHUNK_WIDTH'(b_q >> (32'(idx_q) * CHUNK_WIDTH));
    inv_msb_c = signed_q && (idx_q == TOP_IDX);
  end

  comparator_chunk #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_chunk (
    .Chunk_A_In    (chunk_a_c),
    .Chunk_B_In    (chunk_b_c),
    .Invert_MSB_In (inv_msb_c),
    .gt_c          (gt_c),
    .eq_c          (eq_c),
    .lt_c          (lt_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start_In) begin
          state_d = COMPARE;
          load_c  = 1'b1;
        end
      end
      COMPARE: begin
        if (!eq_c || (idx_q == '0)) begin
          state_d = DONE;
          flags_d = eq_c ? EQ : (gt_c ? GT : LT);
        end else begin
          step_c = 1'b1;
        end
      end
      DONE: begin
        if (Start_In) begin
          state_d = COMPARE;
          load_c  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (lt_c && gt_c) flags_d = flags_q;  // unreachable; keeps gt/lt both consumed
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      busy_q  <= (state_d == COMPARE);
      done_q  <= (state_d == DONE);
    end
  end

  // Operand capture and chunk index walk.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
    end else if (load_c) begin
      a_q      <= Data_A_In;
      b_q      <= Data_B_In;
      signed_q <= Signed_Mode_In;
      idx_q    <= TOP_IDX;
    end else if (step_c) begin
      idx_q    <= idx_q - IDX_W'(1);
    end
  end

  assign Busy_Out   = busy_q;
  assign Done_Out   = done_q;
  assign A_gt_B_Out = Enable_In ? flags_q.gt : 1'bz;
  assign A_eq_B_Out = Enable_In ? flags_q.eq : 1'bz;
  assign A_lt_B_Out = Enable_In ? flags_q.lt : 1'bz;

endmodule

// File: tb/tb_comparator_n_bit_serial.sv
// Bench for comparator_n_bit_serial: directed scenarios plus randomized
// operands against an arithmetic reference model.
module tb_comparator_n_bit_serial;
  import comparator_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NC = DW / CW;

  logic          Clk_In;
  logic          Reset_In;
  logic          Enable_In;
  logic          Start_In;
  logic          Signed_Mode_In;
  logic [DW-1:0] Data_A_In;
  logic [DW-1:0] Data_B_In;
  logic          Busy_Out;
  logic          Done_Out;
  wire           A_gt_B_Out;
  wire           A_eq_B_Out;
  wire           A_lt_B_Out;

  int checks = 0;
  int errors = 0;

  comparator_n_bit_serial #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (CW)
  ) dut (
    .Clk_In         (Clk_In),
    .Reset_In       (Reset_In),
    .Enable_In      (Enable_In),
    .Start_In       (Start_In),
    .Signed_Mode_In (Signed_Mode_In),
    .Data_A_In      (Data_A_In),
    .Data_B_In      (Data_B_In),
    .Busy_Out       (Busy_Out),
    .Done_Out       (Done_Out),
    .A_gt_B_Out     (A_gt_B_Out),
    .A_eq_B_Out     (A_eq_B_Out),
    .A_lt_B_Out     (A_lt_B_Out)
  );

  initial begin
    Clk_In = 1'b0;
    #50;
    forever #5 Clk_In = ~Clk_In;
  end

  function automatic logic [2:0] flags_now();
    return {A_gt_B_Out, A_eq_B_Out, A_lt_B_Out};
  endfunction

  // Reference: ordinary signed/unsigned relational result.
  function automatic logic [2:0] ref_flags(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic sm);
    if (sm) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Reference latency: chunks down to and including the highest differing bit.
  function automatic int ref_latency(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    d = a ^ b;
    for (int p = DW - 1; p >= 0; p--)
      if (d[p]) return NC - (p / CW);
    return NC;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Released flags must read high-impedance (a 2-state simulator resolves Z to 0).
  task automatic check_z(input string tag, input logic [2:0] obs);
    checks++;
    assert ((obs === 3'bzzz) || (obs === 3'b000))
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=zzz", tag, obs);
    end
  endtask

  // Call at a negedge; returns just after the accepting edge.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sm);
    Data_A_In      = a;
    Data_B_In      = b;
    Signed_Mode_In = sm;
    Start_In       = 1'b1;
    @(posedge Clk_In);
    #1;
    Start_In       = 1'b0;
    Data_A_In      = $urandom;
    Data_B_In      = $urandom;
    Signed_Mode_In = 1'($urandom_range(0, 1));
  endtask

  // Returns at the negedge of the DONE cycle (or after the bound expires).
  task automatic wait_done(input string tag, input logic [2:0] exp_f, input int exp_k);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= int'(NC) + 2 && !seen; i++) begin
      @(posedge Clk_In);
      @(negedge Clk_In);
      n = i;
      if (Done_Out === 1'b1) seen = 1'b1;
      else check({tag, " busy"}, 32'(Busy_Out), 32'd1);
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_k));
    check({tag, " flags"}, 32'(flags_now()), 32'(exp_f));
    check({tag, " busy_at_done"}, 32'(Busy_Out), 32'd0);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge Clk_In);
    check({tag, " done_fall"}, 32'(Done_Out), 32'd0);
    check({tag, " busy_idle"}, 32'(Busy_Out), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    logic          rs;
    int            j;
    bit            any_done;

    Reset_In       = 1'b0;
    Enable_In      = 1'b1;
    Start_In       = 1'b0;
    Signed_Mode_In = 1'b0;
    Data_A_In      = '0;
    Data_B_In      = '0;

    // Reset without a running clock.
    #2 Reset_In = 1'b1;
    #3;
    check("rst flags", 32'(flags_now()), 32'd0);
    check("rst busy", 32'(Busy_Out), 32'd0);
    check("rst done", 32'(Done_Out), 32'd0);
    Enable_In = 1'b0;
    #1;
    check_z("rst flags_z", flags_now());
    Enable_In = 1'b1;
    @(negedge Clk_In);
    Reset_In = 1'b0;
    @(negedge Clk_In);

    // Top chunk decides, unsigned then signed.
    start_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_done("uns_top", GT, 1);
    expect_idle("uns_top");
    start_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    wait_done("sgn_top", LT, 1);
    expect_idle("sgn_top");

    // Equal operands, then back-to-back start in the DONE cycle.
    start_op(32'h1234_5678, 32'h1234_5678, 1'b0);
    wait_done("equal", EQ, 4);
    start_op(32'h0000_00FF, 32'h0000_0100, 1'b0);
    wait_done("b2b", LT, 3);
    expect_idle("b2b");

    // Start during COMPARE is ignored; flags tri-state while Enable_In is low.
    start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
    @(negedge Clk_In);
    Data_A_In = 32'hFFFF_FFFF;
    Start_In  = 1'b1;
    @(posedge Clk_In);
    #1;
    Start_In  = 1'b0;
    Enable_In = 1'b0;
    @(negedge Clk_In);
    check("ign busy_e1", 32'(Busy_Out), 32'd1);
    check_z("ign z_e1", flags_now());
    @(posedge Clk_In);
    @(negedge Clk_In);
    check("ign done_e2", 32'(Done_Out), 32'd0);
    check_z("ign z_e2", flags_now());
    @(posedge Clk_In);
    @(negedge Clk_In);
    check("ign done_e3", 32'(Done_Out), 32'd0);
    check_z("ign z_e3", flags_now());
    @(posedge Clk_In);
    @(negedge Clk_In);
    check("ign done_e4", 32'(Done_Out), 32'd1);
    check_z("ign z_e4", flags_now());
    Enable_In = 1'b1;
    #1;
    check("ign flags", 32'(flags_now()), 32'(LT));
    expect_idle("ign");

    // Reset mid-compare discards the operation.
    start_op(32'h1122_3344, 32'h1122_3345, 1'b0);
    @(posedge Clk_In);
    @(negedge Clk_In);
    Reset_In = 1'b1;
    #1;
    check("midrst busy", 32'(Busy_Out), 32'd0);
    check("midrst done", 32'(Done_Out), 32'd0);
    check("midrst flags", 32'(flags_now()), 32'd0);
    @(negedge Clk_In);
    Reset_In = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk_In);
      if (Done_Out !== 1'b0) any_done = 1'b1;
    end
    check("midrst no_done", 32'(any_done), 32'd0);
    start_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    wait_done("post_rst", LT, 1);
    expect_idle("post_rst");

    // Randomized operands with a controlled first-difference chunk.
    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      j  = int'($urandom_range(0, NC));
      if (j == int'(NC)) rb = ra;
      else rb = ra ^ (32'($urandom_range(1, 255)) << (CW * j));
      start_op(ra, rb, rs);
      wait_done("rand", ref_flags(ra, rb, rs), ref_latency(ra, rb));
      if ($urandom_range(0, 1) == 0) expect_idle("rand");
    end
    @(negedge Clk_In);
    @(negedge Clk_In);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
